// File: rtl/flash_ctrl_banked_if.sv
// Bus bundle between the 68k decode, the flash controller and the flash pins.
//   master : CPU/board side. Drives A, AS_n, DS_n, RW_n and the flash ready
//            line FLASH_BUSY_n. Observes the decode hit, DTACK and the flash
//            strobes and address.
//   slave  : flash controller. Consumes the CPU cycle and the busy line.
//            Drives flash_access, flash_dtack_n, FLASH_OE_n, FLASH_WE_n,
//            FLASH_RESET_n and FLASH_AH.
interface flash_ctrl_banked_if #(
  parameter int BANK_BITS = 1
);
  logic [23:1]        A;
  logic               AS_n;
  logic               DS_n;
  logic               RW_n;
  logic               FLASH_BUSY_n;
  logic               flash_access;
  logic               flash_dtack_n;
  logic               FLASH_OE_n;
  logic               FLASH_WE_n;
  logic               FLASH_RESET_n;
  logic [BANK_BITS:0] FLASH_AH;

  modport master (
    output A, AS_n, DS_n, RW_n, FLASH_BUSY_n,
    input  flash_access, flash_dtack_n, FLASH_OE_n, FLASH_WE_n,
           FLASH_RESET_n, FLASH_AH
  );

  modport slave (
    input  A, AS_n, DS_n, RW_n, FLASH_BUSY_n,
    output flash_access, flash_dtack_n, FLASH_OE_n, FLASH_WE_n,
           FLASH_RESET_n, FLASH_AH
  );
endinterface

// File: rtl/flash_ctrl_banked.sv
// Banked flash / MAPROM controller.
// Decodes 68k cycles into the flash windows, runs a wait-state FSM that drives
// the flash OE_n/WE_n strobes and DTACK, waits (with a timeout) for the flash
// to report ready, and selects one of 2^BANK_BITS ROM banks latched at reset.
// Ports:
//   CLKCPU         CPU clock, every state change on its rising edge
//   RESET          synchronous active-high reset; also latches the MAPROM
//                  mode and the ROM bank
//   enable_maprom  MAPROM mode request (sampled only while RESET=1)
//   rom_bank       ROM bank select    (sampled only while RESET=1)
//   busy_timeout   sticky flag: a busy-wait ran out of time
//   bus            slave side of flash_ctrl_banked_if (CPU cycle in,
//                  decode hit / DTACK / flash pins out)
module flash_ctrl_banked #(
  parameter int         BANK_BITS    = 1,
  parameter int         WAIT_RD      = 2,
  parameter int         WAIT_WR      = 3,
  parameter int         BUSY_TIMEOUT = 255,
  parameter logic [7:0] OVL_CLR_PAGE = 8'hBF
) (
  input  logic                 CLKCPU,
  input  logic                 RESET,
  input  logic                 enable_maprom,
  input  logic [BANK_BITS-1:0] rom_bank,
  output logic                 busy_timeout,
  flash_ctrl_banked_if.slave   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BWAIT  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WSETUP = 3'd3;
  localparam logic [2:0] ST_WPULSE = 3'd4;
  localparam logic [2:0] ST_ACK    = 3'd5;

  localparam int            TW      = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [3:0]    RD_INIT = 4'(WAIT_RD);
  localparam logic [3:0]    WR_INIT = 4'(WAIT_WR);
  localparam logic [TW-1:0] TO_INIT = TW'(BUSY_TIMEOUT);

  logic [2:0]           state_reg;
  logic [3:0]           cnt_reg;
  logic [TW-1:0]        tcnt_reg;
  logic                 oe_n_reg;
  logic                 we_n_reg;
  logic                 dtack_n_reg;
  logic                 busy_timeout_reg;
  logic                 ovl_reg;
  logic                 ovl_cycle_reg;
  logic                 maprom_en_reg;
  logic [BANK_BITS-1:0] bank_reg;

  logic                 ovl_eff;
  logic [BANK_BITS-1:0] bank_eff;
  logic                 win_low;
  logic                 win_a;
  logic                 win_f8;
  logic                 win_e0;
  logic                 hit;
  logic                 ovl_clr;
  logic [2:0]           disp_state;
  logic                 disp_oe_n;
  logic                 unused_addr_bits;

  // The overlay seen by a flash cycle is frozen when the cycle leaves IDLE,
  // so a concurrent overlay clear cannot move FLASH_AH under a running access.
  assign ovl_eff = (state_reg == ST_IDLE) ? ovl_reg : ovl_cycle_reg;

  // Without MAPROM the bank select has no meaning; force it to bank 0.
  for (genvar gi = 0; gi < BANK_BITS; gi++) begin : g_bank
    assign bank_eff[gi] = bank_reg[gi] & maprom_en_reg;
  end

  // Window decode
  assign win_a   = (bus.A[23:20] == 4'hA)     && !maprom_en_reg;
  assign win_low = (bus.A[23:20] == 4'h0)     &&  maprom_en_reg && ovl_eff;
  assign win_f8  = (bus.A[23:19] == 5'b11111) &&  maprom_en_reg;
  assign win_e0  = (bus.A[23:19] == 5'b11100) &&  maprom_en_reg;
  assign hit     = win_a || win_low || win_f8 || win_e0;

  // A CPU write into the CIA page drops the boot overlay.
  assign ovl_clr = (bus.A[23:16] == OVL_CLR_PAGE) && !bus.AS_n && !bus.RW_n;

  // Where a cycle goes once the flash is ready (shared by IDLE and BWAIT).
  // MAPROM writes are acknowledged without ever pulsing WE_n.
  always_comb begin
    disp_state = ST_ACK;
    disp_oe_n  = 1'b1;
    if (bus.RW_n) begin
      disp_state = ST_READ;
      disp_oe_n  = 1'b0;
    end else if (!maprom_en_reg) begin
      disp_state = ST_WSETUP;
    end
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= 4'd0;
      tcnt_reg         <= '0;
      oe_n_reg         <= 1'b1;
      we_n_reg         <= 1'b1;
      dtack_n_reg      <= 1'b1;
      busy_timeout_reg <= 1'b0;
      ovl_reg          <= 1'b1;
      ovl_cycle_reg    <= 1'b1;
      maprom_en_reg    <= enable_maprom;
      bank_reg         <= rom_bank;
    end else begin
      if (ovl_clr) begin
        ovl_reg <= 1'b0;
      end

      if (bus.AS_n) begin
        // End of bus cycle, or an abort: release everything at once.
        // A write pulse cut short here is acceptable to the flash.
        state_reg   <= ST_IDLE;
        oe_n_reg    <= 1'b1;
        we_n_reg    <= 1'b1;
        dtack_n_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (hit) begin
              ovl_cycle_reg <= ovl_reg;
              if (!bus.FLASH_BUSY_n) begin
                state_reg <= ST_BWAIT;
                tcnt_reg  <= TO_INIT;
              end else begin
                state_reg <= disp_state;
                oe_n_reg  <= disp_oe_n;
                cnt_reg   <= RD_INIT;
              end
            end
          end

          ST_BWAIT: begin
            if (bus.FLASH_BUSY_n) begin
              state_reg <= disp_state;
              oe_n_reg  <= disp_oe_n;
              cnt_reg   <= RD_INIT;
            end else if (tcnt_reg == '0) begin
              // Give up waiting: flag it and run the cycle anyway so the
              // CPU is never left without DTACK.
              busy_timeout_reg <= 1'b1;
              state_reg        <= disp_state;
              oe_n_reg         <= disp_oe_n;
              cnt_reg          <= RD_INIT;
            end else begin
              tcnt_reg <= tcnt_reg - TW'(1);
            end
          end

          ST_READ: begin
            if (cnt_reg == 4'd0) begin
              state_reg   <= ST_ACK;
              dtack_n_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end

          ST_WSETUP: begin
            if (!bus.DS_n) begin
              state_reg <= ST_WPULSE;
              we_n_reg  <= 1'b0;
              cnt_reg   <= WR_INIT;
            end
          end

          ST_WPULSE: begin
            if (cnt_reg == 4'd0) begin
              state_reg   <= ST_ACK;
              we_n_reg    <= 1'b1;
              dtack_n_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end

          ST_ACK: begin
            // Entered directly from dispatch for ignored writes, so DTACK
            // is asserted here rather than on the transition.
            dtack_n_reg <= 1'b0;
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.flash_access  = hit;
  assign bus.flash_dtack_n = dtack_n_reg;
  assign bus.FLASH_OE_n    = oe_n_reg;
  assign bus.FLASH_WE_n    = we_n_reg;
  assign bus.FLASH_RESET_n = ~RESET;
  assign bus.FLASH_AH      = {bank_eff, bus.A[19] | ovl_eff};
  assign busy_timeout      = busy_timeout_reg;

  // Word offset inside a 64 KiB page does not affect decoding.
  assign unused_addr_bits = ^bus.A[15:1];

endmodule

// File: tb/tb_flash_ctrl_banked.sv
// Self-checking bench for flash_ctrl_banked: directed scenarios plus a
// randomized run checked against an address-range / latency model.
module tb_flash_ctrl_banked;
  localparam int BB  = 1;
  localparam int WRD = 2;
  localparam int WWR = 3;
  localparam int BT  = 4;

  logic          CLKCPU = 1'b0;
  logic          RESET;
  logic          enable_maprom;
  logic [BB-1:0] rom_bank;
  logic          busy_timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_maprom;
  bit [BB-1:0] m_bank;
  bit          m_ovl;
  bit          m_to;

  flash_ctrl_banked_if #(.BANK_BITS(BB)) bus ();

  flash_ctrl_banked #(
    .BANK_BITS(BB), .WAIT_RD(WRD), .WAIT_WR(WWR),
    .BUSY_TIMEOUT(BT), .OVL_CLR_PAGE(8'hBF)
  ) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .enable_maprom(enable_maprom),
    .rom_bank(rom_bank), .busy_timeout(busy_timeout), .bus(bus)
  );

  always #5 CLKCPU = ~CLKCPU;

  // Flash windows as byte-address ranges.
  function automatic bit m_hit(input logic [23:0] addr);
    int unsigned a;
    a = addr;
    if (!m_maprom) return (a >= 32'hA00000 && a <= 32'hAFFFFF);
    if (m_ovl && a <= 32'h0FFFFF) return 1'b1;
    if (a >= 32'hF80000) return 1'b1;
    if (a >= 32'hE00000 && a <= 32'hE7FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_ah(input logic [23:0] addr);
    logic [1:0] r;
    r[1] = m_maprom ? m_bank[0] : 1'b0;
    r[0] = addr[19] | m_ovl;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic do_reset(input bit mr, input logic [BB-1:0] bk);
    RESET = 1'b1; enable_maprom = mr; rom_bank = bk;
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.RW_n = 1'b1; bus.FLASH_BUSY_n = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    // change the straps afterwards: the controller must keep the latched values
    enable_maprom = ~mr; rom_bank = ~bk;
    m_maprom = mr; m_bank = bk; m_ovl = 1'b1; m_to = 1'b0;
    tick();
  endtask

  // Runs one CPU cycle. Edge 0 is the first edge sampling AS_n low. DS_n is
  // low from edge ds_at on; FLASH_BUSY_n is low for edges below busy_for.
  // Returns the first edge at which each strobe was seen low (-1 = never).
  task automatic run_txn(input logic [23:0] addr, input bit rd, input int ds_at,
                         input int busy_for, output bit acc, output logic [1:0] ah,
                         output int oe_lo, output int we_lo, output int we_hi,
                         output int dt_lo, output bit dt_held, output int to_at,
                         output bit idle_ok);
    bit to_before;
    to_before = busy_timeout;
    bus.A = addr[23:1]; bus.RW_n = rd; bus.AS_n = 1'b0;
    bus.DS_n = (ds_at <= 0) ? 1'b0 : 1'b1;
    bus.FLASH_BUSY_n = (busy_for > 0) ? 1'b0 : 1'b1;
    #1;
    acc = bus.flash_access; ah = bus.FLASH_AH;
    oe_lo = -1; we_lo = -1; we_hi = -1; dt_lo = -1; dt_held = 1'b0; to_at = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge CLKCPU); #1;
      if (oe_lo < 0 && bus.FLASH_OE_n === 1'b0) oe_lo = e;
      if (we_lo < 0 && bus.FLASH_WE_n === 1'b0) we_lo = e;
      if (we_lo >= 0 && we_hi < 0 && bus.FLASH_WE_n === 1'b1) we_hi = e;
      if (dt_lo < 0 && bus.flash_dtack_n === 1'b0) dt_lo = e;
      if (!to_before && to_at < 0 && busy_timeout === 1'b1) to_at = e;
      if (dt_lo >= 0 && e == dt_lo + 2) begin
        dt_held = (bus.flash_dtack_n === 1'b0);
        break;
      end
      bus.DS_n = (e + 1 >= ds_at) ? 1'b0 : 1'b1;
      bus.FLASH_BUSY_n = (e + 1 >= busy_for) ? 1'b1 : 1'b0;
    end
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.FLASH_BUSY_n = 1'b1;
    tick();
    idle_ok = (bus.FLASH_OE_n === 1'b1) && (bus.FLASH_WE_n === 1'b1) &&
              (bus.flash_dtack_n === 1'b1);
    $display("txn addr=%h rd=%0d ds=%0d busy=%0d acc=%0d ah=%b oe=%0d we=%0d/%0d dtack=%0d to=%0d",
             addr, rd, ds_at, busy_for, acc, ah, oe_lo, we_lo, we_hi, dt_lo, busy_timeout);
  endtask

  task automatic test_reset();
    RESET = 1'b1; enable_maprom = 1'b1; rom_bank = 1'b1;
    bus.A = 23'(24'hF80000 >> 1); bus.RW_n = 1'b1; bus.AS_n = 1'b0;
    bus.DS_n = 1'b0; bus.FLASH_BUSY_n = 1'b1;
    tick(); tick();
    checks++; if (bus.FLASH_OE_n !== 1'b1) begin errors++; $display("FAIL reset_oe got %b want 1", bus.FLASH_OE_n); end
    checks++; if (bus.FLASH_WE_n !== 1'b1) begin errors++; $display("FAIL reset_we got %b want 1", bus.FLASH_WE_n); end
    checks++; if (bus.flash_dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack got %b want 1", bus.flash_dtack_n); end
    checks++; if (busy_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", busy_timeout); end
    checks++; if (bus.FLASH_RESET_n !== 1'b0) begin errors++; $display("FAIL reset_flash_rst got %b want 0", bus.FLASH_RESET_n); end
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    RESET = 1'b0; enable_maprom = 1'b0; rom_bank = 1'b0;
    m_maprom = 1'b1; m_bank = 1'b1; m_ovl = 1'b1; m_to = 1'b0;
    #1;
    checks++; if (bus.FLASH_RESET_n !== 1'b1) begin errors++; $display("FAIL release_flash_rst got %b want 1", bus.FLASH_RESET_n); end
    tick();
  endtask

  task automatic test_maprom_read();
    bit acc, held, idl; logic [1:0] ah; int oe, wl, wh, dt, to;
    run_txn(24'h000100, 1'b1, 0, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL low_read_acc got %b want 1", acc); end
    checks++; if (ah !== m_ah(24'h000100)) begin errors++; $display("FAIL low_read_ah got %b want %b", ah, m_ah(24'h000100)); end
    checks++; if (oe !== 0) begin errors++; $display("FAIL low_read_oe got %0d want 0", oe); end
    checks++; if (dt !== WRD + 1) begin errors++; $display("FAIL low_read_dtack got %0d want %0d", dt, WRD + 1); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL low_read_dtack_held got %b want 1", held); end
    checks++; if (idl !== 1'b1) begin errors++; $display("FAIL low_read_release got %b want 1", idl); end
  endtask

  task automatic test_overlay_clear();
    bit acc, held, idl; logic [1:0] ah; int oe, wl, wh, dt, to;
    run_txn(24'hBFE001, 1'b0, 1, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (acc !== 1'b0 || dt !== -1) begin errors++; $display("FAIL cia_write acc %b dtack %0d want 0/-1", acc, dt); end
    m_ovl = 1'b0;
    run_txn(24'h000100, 1'b1, 0, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL ovl_gone_acc got %b want 0", acc); end
    checks++; if (oe !== -1 || dt !== -1) begin errors++; $display("FAIL ovl_gone_strobes oe %0d dtack %0d want -1", oe, dt); end
    run_txn(24'hF80000, 1'b1, 0, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (ah !== m_ah(24'hF80000)) begin errors++; $display("FAIL f8_ah got %b want %b", ah, m_ah(24'hF80000)); end
    checks++; if (dt !== WRD + 1) begin errors++; $display("FAIL f8_dtack got %0d want %0d", dt, WRD + 1); end
    run_txn(24'hE00000, 1'b1, 0, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (ah !== 2'b10 || acc !== 1'b1) begin errors++; $display("FAIL e0_ah got %b acc %b want 10/1", ah, acc); end
  endtask

  task automatic test_write();
    bit acc, held, idl; logic [1:0] ah; int oe, wl, wh, dt, to;
    do_reset(1'b0, 1'b1);
    run_txn(24'hA00000, 1'b0, 1, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (ah !== 2'b01) begin errors++; $display("FAIL wr_ah got %b want 01", ah); end
    checks++; if (wl !== 1) begin errors++; $display("FAIL wr_we_low got %0d want 1", wl); end
    checks++; if (wh !== 1 + WWR + 1) begin errors++; $display("FAIL wr_we_high got %0d want %0d", wh, 1 + WWR + 1); end
    checks++; if (dt !== 1 + WWR + 1) begin errors++; $display("FAIL wr_dtack got %0d want %0d", dt, 1 + WWR + 1); end
    checks++; if (oe !== -1) begin errors++; $display("FAIL wr_oe got %0d want -1", oe); end
    run_txn(24'h000100, 1'b1, 0, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL nomaprom_low_acc got %b want 0", acc); end
  endtask

  task automatic test_maprom_write();
    bit acc, held, idl; logic [1:0] ah; int oe, wl, wh, dt, to;
    do_reset(1'b1, 1'b0);
    run_txn(24'hF80000, 1'b0, 1, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (wl !== -1) begin errors++; $display("FAIL mwr_we got %0d want -1", wl); end
    checks++; if (dt !== 1) begin errors++; $display("FAIL mwr_dtack got %0d want 1", dt); end
  endtask

  task automatic test_busy_timeout();
    bit acc, held, idl; logic [1:0] ah; int oe, wl, wh, dt, to;
    do_reset(1'b1, 1'b1);
    run_txn(24'hF80000, 1'b1, 0, 3, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (oe !== 3 || dt !== 3 + WRD + 1) begin errors++; $display("FAIL busy_short oe %0d dtack %0d want 3/%0d", oe, dt, 3 + WRD + 1); end
    checks++; if (busy_timeout !== 1'b0) begin errors++; $display("FAIL busy_short_to got %b want 0", busy_timeout); end
    run_txn(24'hF80000, 1'b1, 0, 100, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (to !== BT + 1) begin errors++; $display("FAIL timeout_edge got %0d want %0d", to, BT + 1); end
    checks++; if (oe !== BT + 1 || dt !== BT + 1 + WRD + 1) begin errors++; $display("FAIL timeout_read oe %0d dtack %0d want %0d/%0d", oe, dt, BT + 1, BT + WRD + 2); end
    run_txn(24'hF80000, 1'b1, 0, 0, acc, ah, oe, wl, wh, dt, held, to, idl);
    checks++; if (busy_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", busy_timeout); end
  endtask

  task automatic test_abort();
    do_reset(1'b1, 1'b0);
    bus.A = 23'(24'hF80000 >> 1); bus.RW_n = 1'b1; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    tick(); tick();
    checks++; if (bus.FLASH_OE_n !== 1'b0) begin errors++; $display("FAIL abort_rd_pre got %b want 0", bus.FLASH_OE_n); end
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    tick();
    checks++; if (bus.FLASH_OE_n !== 1'b1 || bus.flash_dtack_n !== 1'b1) begin errors++; $display("FAIL abort_rd oe %b dtack %b want 1/1", bus.FLASH_OE_n, bus.flash_dtack_n); end

    do_reset(1'b0, 1'b0);
    bus.A = 23'(24'hA00000 >> 1); bus.RW_n = 1'b0; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.FLASH_WE_n !== 1'b0) begin errors++; $display("FAIL abort_wr_pre got %b want 0", bus.FLASH_WE_n); end
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    tick();
    checks++; if (bus.FLASH_WE_n !== 1'b1 || bus.flash_dtack_n !== 1'b1) begin errors++; $display("FAIL abort_wr we %b dtack %b want 1/1", bus.FLASH_WE_n, bus.flash_dtack_n); end
    tick();
    checks++; if (bus.FLASH_WE_n !== 1'b1) begin errors++; $display("FAIL abort_wr_stay got %b want 1", bus.FLASH_WE_n); end

    bus.A = 23'(24'hA00000 >> 1); bus.RW_n = 1'b0; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b1; enable_maprom = 1'b1; rom_bank = 1'b1;
    tick();
    checks++; if (bus.FLASH_WE_n !== 1'b1 || bus.flash_dtack_n !== 1'b1 || bus.FLASH_OE_n !== 1'b1) begin errors++; $display("FAIL reset_mid_wr we %b dtack %b oe %b want 1/1/1", bus.FLASH_WE_n, bus.flash_dtack_n, bus.FLASH_OE_n); end
    RESET = 1'b0; bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    m_maprom = 1'b1; m_bank = 1'b1; m_ovl = 1'b1; m_to = 1'b0;
    tick();
    bus.A = 23'(24'h000100 >> 1); bus.RW_n = 1'b1;
    #1;
    checks++; if (bus.flash_access !== m_hit(24'h000100) || bus.FLASH_AH !== m_ah(24'h000100)) begin errors++; $display("FAIL reset_relatch acc %b ah %b want %b/%b", bus.flash_access, bus.FLASH_AH, m_hit(24'h000100), m_ah(24'h000100)); end
    tick();
  endtask

  task automatic test_random();
    logic [23:0] bases [15];
    bases = '{24'h000100, 24'h07FFFE, 24'h080000, 24'hA00000, 24'hA80000,
              24'hAFFFFE, 24'hF80000, 24'hFFFFFE, 24'hE00000, 24'hE7FFFE,
              24'hBFE001, 24'hBFD000, 24'h900000, 24'hE80000, 24'hF00000};
    for (int n = 0; n < 60; n++) begin
      bit acc, held, idl, rd, h; logic [1:0] ah, eah; logic [23:0] addr;
      int oe, wl, wh, dt, to, ds, bz, d0, e_oe, e_wl, e_wh, e_dt;
      if ($urandom_range(0, 7) == 0) do_reset(1'($urandom_range(0, 1)), BB'($urandom_range(0, 1)));
      addr = bases[$urandom_range(0, 14)] ^ 24'($urandom_range(0, 16'hFFFF) & 32'hFFFE);
      rd = 1'($urandom_range(0, 1));
      ds = $urandom_range(0, 3);
      bz = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      h = m_hit(addr); eah = m_ah(addr);
      e_oe = -1; e_wl = -1; e_wh = -1; e_dt = -1;
      if (h) begin
        // flash ready edge: immediately, when busy ends, or when patience runs out
        d0 = (bz == 0) ? 0 : ((bz <= BT + 1) ? bz : BT + 1);
        if (bz >= BT + 2) m_to = 1'b1;
        if (rd) begin
          e_oe = d0; e_dt = d0 + WRD + 1;
        end else if (!m_maprom) begin
          e_wl = (ds > d0 + 1) ? ds : d0 + 1;
          e_wh = e_wl + WWR + 1; e_dt = e_wh;
        end else begin
          e_dt = d0 + 1;
        end
      end
      run_txn(addr, rd, ds, bz, acc, ah, oe, wl, wh, dt, held, to, idl);
      if (!rd && addr[23:16] == 8'hBF) m_ovl = 1'b0;
      checks++; if (acc !== h || ah !== eah) begin errors++; $display("FAIL rnd%0d_decode acc %b ah %b want %b/%b", n, acc, ah, h, eah); end
      checks++; if (oe !== e_oe || wl !== e_wl || wh !== e_wh || dt !== e_dt) begin errors++; $display("FAIL rnd%0d_timing oe/we/we_hi/dtack %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n, oe, wl, wh, dt, e_oe, e_wl, e_wh, e_dt); end
      checks++; if (idl !== 1'b1 || busy_timeout !== m_to) begin errors++; $display("FAIL rnd%0d_end release %b timeout %b want 1/%b", n, idl, busy_timeout, m_to); end
    end
  endtask

  initial begin
    RESET = 1'b1; enable_maprom = 1'b0; rom_bank = '0;
    bus.A = '0; bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.RW_n = 1'b1; bus.FLASH_BUSY_n = 1'b1;
    test_reset();
    test_maprom_read();
    test_overlay_clear();
    test_write();
    test_maprom_write();
    test_busy_timeout();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
